// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM-style pipeline hazard control.
// Holds the memory-wait FSM encoding and the ALU operand forward selects.
package arm_pipe_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hzState_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [3:0] REG_PC = 4'hF;

  // R15 is never forwarded: its read value comes from the PC path, not the ALU result.
  function automatic logic [1:0] fwdSelect(
    input logic [3:0] srcReg,
    input logic       regWriteM,
    input logic [3:0] wa3M,
    input logic       regWriteW,
    input logic [3:0] wa3W
  );
    if (srcReg == REG_PC) begin
      return FWD_RF;
    end
    if (regWriteM && (srcReg == wa3M)) begin
      return FWD_MEM;
    end
    if (regWriteW && (srcReg == wa3W)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
// Clear wins over increment; the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] val);
    return (val == CNT_MAX) ? val : val + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= satInc(cnt);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for a 5-stage ARM-style pipeline: forwarding, load-use and PC-write
// stalls, branch flushes, a data-memory wait FSM with timeout, and perf counters.
module pipe_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  input  logic             cnt_clr,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W:0] TMO_LAST = (TMO_W + 1)'(MEM_TIMEOUT);

  hzState_e         state;
  hzState_e         stateNxt;
  logic [TMO_W-1:0] tmoCnt;
  logic [TMO_W:0]   tmoNext;
  logic             tmoHit;
  logic             tmoFire;
  logic             ldrStall;
  logic             pcWrPend;
  logic             memStall;

  assign ldrStall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
  assign pcWrPend = PCSrcD || PCSrcE || PCSrcM;
  // Combinational so the pipeline freezes in the very cycle the request misses.
  assign memStall = MemReqM && !MemAckM && !mem_timeout;

  assign tmoNext = {1'b0, tmoCnt} + (TMO_W + 1)'(1);
  assign tmoHit  = (tmoNext >= TMO_LAST);
  assign tmoFire = (state == MEMWAIT) && !MemAckM && tmoHit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= stateNxt;
    end
  end

  // Counter sits at zero throughout RUN, so every MEMWAIT entry starts from a clean count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmoCnt      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (state == RUN) begin
        tmoCnt <= '0;
      end else begin
        tmoCnt <= tmoNext[TMO_W-1:0];
      end
      if (tmoFire) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      RUN: begin
        if (memStall) begin
          stateNxt = MEMWAIT;
        end
      end
      MEMWAIT: begin
        if (MemAckM || tmoHit) begin
          stateNxt = RUN;
        end
      end
      default: stateNxt = RUN;
    endcase
  end

  // A memory stall freezes everything up to M and parks branch/PC flushes until release.
  always_comb begin
    ForwardAE = fwdSelect(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    ForwardBE = fwdSelect(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
    StallF    = ldrStall || pcWrPend || memStall;
    StallD    = ldrStall || memStall;
    StallE    = memStall;
    StallM    = memStall;
    FlushD    = !memStall && (pcWrPend || PCSrcW || BranchTakenE);
    FlushE    = !memStall && (ldrStall || BranchTakenE);
    FlushW    = memStall;
    if (reset) begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallF),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (FlushE),
    .clr   (cnt_clr),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (short timeout / 4-bit counters,
// and defaults) share one stimulus stream checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;
  import arm_pipe_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic       MemReqM, MemAckM, cnt_clr;

  logic [1:0]  fa0, fb0, fa1, fb1;
  logic        sF0, sD0, sE0, sM0, fD0, fE0, fW0, mto0;
  logic        sF1, sD1, sE1, sM1, fD1, fE1, fW1, mto1;
  logic [3:0]  sc0, fc0;
  logic [15:0] sc1, fc1;

  pipe_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(3)) u0 (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .cnt_clr(cnt_clr), .ForwardAE(fa0), .ForwardBE(fb0), .StallF(sF0), .StallD(sD0),
    .StallE(sE0), .StallM(sM0), .FlushD(fD0), .FlushE(fE0), .FlushW(fW0),
    .mem_timeout(mto0), .stall_cnt(sc0), .flush_cnt(fc0)
  );

  pipe_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(255)) u1 (
    .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemAckM(MemAckM),
    .cnt_clr(cnt_clr), .ForwardAE(fa1), .ForwardBE(fb1), .StallF(sF1), .StallD(sD1),
    .StallE(sE1), .StallM(sM1), .FlushD(fD1), .FlushE(fE1), .FlushW(fW1),
    .mem_timeout(mto1), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] fa, fb;
    logic       sF, sD, sE, sM, fD, fE, fW, mto;
    int         sc, fc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: length of the current unanswered request, sticky abort, counts.
  int age[2];
  bit tout[2];
  int scM[2];
  int fcM[2];
  bit inTx;
  int memLeft;

  function automatic int tmoOf(input int i);
    return (i == 0) ? 3 : 255;
  endfunction

  function automatic int cmaxOf(input int i);
    return (i == 0) ? 15 : 65535;
  endfunction

  function automatic logic [1:0] fwdRef(input logic [3:0] ra);
    if (ra == 4'hF) return 2'b00;
    if (RegWriteM && ra == WA3M) return 2'b10;
    if (RegWriteW && ra == WA3W) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] rreg();
    int v = $urandom_range(0, 4);
    return (v == 4) ? 4'hF : 4'(v);
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic cmpOut(input string tag, input exp_t e, input exp_t a);
    chk({tag, "_ForwardAE"}, int'(a.fa), int'(e.fa));
    chk({tag, "_ForwardBE"}, int'(a.fb), int'(e.fb));
    chk({tag, "_StallF"}, int'(a.sF), int'(e.sF));
    chk({tag, "_StallD"}, int'(a.sD), int'(e.sD));
    chk({tag, "_StallE"}, int'(a.sE), int'(e.sE));
    chk({tag, "_StallM"}, int'(a.sM), int'(e.sM));
    chk({tag, "_FlushD"}, int'(a.fD), int'(e.fD));
    chk({tag, "_FlushE"}, int'(a.fE), int'(e.fE));
    chk({tag, "_FlushW"}, int'(a.fW), int'(e.fW));
    chk({tag, "_mem_timeout"}, int'(a.mto), int'(e.mto));
    chk({tag, "_stall_cnt"}, a.sc, e.sc);
    chk({tag, "_flush_cnt"}, a.fc, e.fc);
  endtask

  // Monitor: pops one expected record per instance every cycle, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a.fa = fa0; a.fb = fb0; a.sF = sF0; a.sD = sD0; a.sE = sE0; a.sM = sM0;
      a.fD = fD0; a.fE = fE0; a.fW = fW0; a.mto = mto0; a.sc = int'(sc0); a.fc = int'(fc0);
      cmpOut("u0", e, a);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a.fa = fa1; a.fb = fb1; a.sF = sF1; a.sD = sD1; a.sE = sE1; a.sM = sM1;
      a.fD = fD1; a.fE = fE1; a.fW = fW1; a.mto = mto1; a.sc = int'(sc1); a.fc = int'(fc1);
      cmpOut("u1", e, a);
    end
  end

  // Push this cycle's expectations from the current inputs, advance the model, wait a cycle.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      bit   ld, pc, ms;
      ms = MemReqM && !MemAckM && !tout[i];
      ld = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
      pc = PCSrcD || PCSrcE || PCSrcM;
      if (reset) begin
        e.fa = 2'b00; e.fb = 2'b00;
        e.sF = 0; e.sD = 0; e.sE = 0; e.sM = 0;
        e.fD = 1; e.fE = 1; e.fW = 1; e.mto = 0; e.sc = 0; e.fc = 0;
        age[i] = 0; tout[i] = 0; scM[i] = 0; fcM[i] = 0;
      end else begin
        e.fa  = fwdRef(RA1E);
        e.fb  = fwdRef(RA2E);
        e.sF  = ld || pc || ms;
        e.sD  = ld || ms;
        e.sE  = ms;
        e.sM  = ms;
        e.fD  = !ms && (pc || PCSrcW || BranchTakenE);
        e.fE  = !ms && (ld || BranchTakenE);
        e.fW  = ms;
        e.mto = tout[i];
        e.sc  = scM[i];
        e.fc  = fcM[i];
        if (cnt_clr) begin
          scM[i] = 0;
          fcM[i] = 0;
        end else begin
          if (e.sF && scM[i] < cmaxOf(i)) scM[i]++;
          if (e.fE && fcM[i] < cmaxOf(i)) fcM[i]++;
        end
        if (ms) begin
          age[i]++;
          if (age[i] > tmoOf(i)) begin
            tout[i] = 1;
            age[i]  = 0;
          end
        end else begin
          age[i] = 0;
        end
      end
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idleIn();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
    RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; BranchTakenE = 0;
    MemReqM = 0; MemAckM = 0; cnt_clr = 0;
  endtask

  task automatic doReset();
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idleIn();
    @(posedge clk);
    #2;
    // reset values, with forwarding inputs that would otherwise select M
    RegWriteM = 1; WA3M = 3; RA1E = 3;
    #1;
    chk("rst_StallF", sF1, 0);
    chk("rst_FlushD", fD1, 1);
    chk("rst_FlushW", fW1, 1);
    chk("rst_ForwardAE", int'(fa1), 0);
    step();
    step();
    reset = 0;

    // forwarding priority and R15 exclusion
    RegWriteM = 1; WA3M = 3; RA1E = 3; RegWriteW = 1; WA3W = 3;
    #1; chk("fwd_mem_prio", int'(fa1), 2);
    step();
    RA1E = 15;
    #1; chk("fwd_r15", int'(fa1), 0);
    step();
    RA1E = 3; RegWriteM = 0;
    #1; chk("fwd_wb", int'(fa1), 1);
    step();
    idleIn();

    // load-use stall for one cycle
    cnt_clr = 1; step(); cnt_clr = 0;
    MemtoRegE = 1; WA3E = 5; RA2D = 5;
    #1;
    chk("ldr_StallF", sF1, 1);
    chk("ldr_StallD", sD1, 1);
    chk("ldr_FlushE", fE1, 1);
    step();
    idleIn();
    #1;
    chk("ldr_StallF_after", sF1, 0);
    chk("ldr_stall_cnt", int'(sc1), 1);
    step();

    // memory wait with ack after four cycles
    MemReqM = 1; MemAckM = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("mw_StallF", sF1, 1);
      chk("mw_StallM", sM1, 1);
      chk("mw_FlushW", fW1, 1);
      step();
    end
    MemAckM = 1;
    #1;
    chk("mw_ack_StallF", sF1, 0);
    chk("mw_ack_FlushW", fW1, 0);
    step();
    idleIn();
    #1; chk("mw_state_run", int'(u1.state == RUN), 1);
    step();

    // branch held during memory stall
    doReset();
    MemReqM = 1; MemAckM = 0; BranchTakenE = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("br_hold_FlushD", fD1, 0);
      chk("br_hold_FlushE", fE1, 0);
      step();
    end
    MemAckM = 1;
    #1;
    chk("br_rel_FlushD", fD1, 1);
    chk("br_rel_FlushE", fE1, 1);
    step();
    idleIn();
    step();

    // timeout on the short-timeout instance
    doReset();
    MemReqM = 1; MemAckM = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("tmo_StallF", sF0, int'(k < 4));
      chk("tmo_flag", mto0, int'(k >= 4));
      step();
    end
    idleIn();
    for (int k = 0; k < 3; k++) begin
      #1; chk("tmo_sticky", mto0, 1);
      step();
    end
    reset = 1;
    #1; chk("tmo_cleared", mto0, 0);
    step();
    reset = 0;

    // counter saturation, clear, then reset in the middle of a memory wait
    cnt_clr = 1; step(); cnt_clr = 0;
    PCSrcD = 1;
    for (int k = 0; k < 20; k++) step();
    PCSrcD = 0;
    #1;
    chk("sat_cnt4", int'(sc0), 15);
    chk("sat_cnt16", int'(sc1), 20);
    step();
    cnt_clr = 1; step(); cnt_clr = 0;
    #1; chk("clr_cnt", int'(sc0), 0);
    step();
    MemReqM = 1; MemAckM = 0;
    step();
    step();
    #1; chk("pre_rst_StallF", sF0, 1);
    reset = 1;
    #1;
    chk("rst_mid_StallF", sF0, 0);
    chk("rst_mid_StallD", sD0, 0);
    chk("rst_mid_StallE", sE0, 0);
    chk("rst_mid_StallM", sM0, 0);
    chk("rst_mid_StallF_u1", sF1, 0);
    step();
    reset = 0;
    MemReqM = 0;
    #1;
    chk("post_rst_StallF", sF0, 0);
    chk("post_rst_state", int'(u0.state == RUN), 1);
    step();

    // randomized traffic; memory requests held until acknowledged
    inTx = 0;
    memLeft = 0;
    for (int n = 0; n < 800; n++) begin
      RA1D = rreg(); RA2D = rreg(); RA1E = rreg(); RA2E = rreg();
      WA3E = rreg(); WA3M = rreg(); WA3W = rreg();
      RegWriteM    = ($urandom_range(0, 1) == 0);
      RegWriteW    = ($urandom_range(0, 1) == 0);
      MemtoRegE    = ($urandom_range(0, 3) == 0);
      PCSrcD       = ($urandom_range(0, 9) == 0);
      PCSrcE       = ($urandom_range(0, 9) == 0);
      PCSrcM       = ($urandom_range(0, 9) == 0);
      PCSrcW       = ($urandom_range(0, 9) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      cnt_clr      = ($urandom_range(0, 39) == 0);
      reset        = ($urandom_range(0, 59) == 0);
      if (!inTx && $urandom_range(0, 3) == 0) begin
        inTx    = 1;
        memLeft = $urandom_range(0, 6);
      end
      if (inTx) begin
        MemReqM = 1;
        if (memLeft == 0) begin
          MemAckM = 1;
          inTx    = 0;
        end else begin
          MemAckM = 0;
          memLeft--;
        end
      end else begin
        MemReqM = 0;
        MemAckM = 0;
      end
      step();
    end
    reset = 0;
    idleIn();
    step();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each performance counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, maximum number of MEMWAIT cycles before abort.
REQ-003 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports RA1D, RA2D  in  4 each  Decode-stage source register numbers.
REQ-006 SHALL have ports RA1E, RA2E  in  4 each  Execute-stage source register numbers.
REQ-007 SHALL have ports WA3E, WA3M, WA3W  in  4 each  destination register of the E, M and W stages.
REQ-008 SHALL have ports RegWriteM, RegWriteW  in  1 each  M/W stage writes the register file.
REQ-009 SHALL have port MemtoRegE  in  1  E-stage instruction is a load.
REQ-010 SHALL have ports PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1 each  the instruction in that stage writes R15.
REQ-011 SHALL have port BranchTakenE  in  1  branch resolved taken in E.
REQ-012 SHALL have ports MemReqM, MemAckM  in  1 each  data-memory request and completion.
REQ-013 SHALL have port cnt_clr  in  1  synchronous clear of both counters.
REQ-014 SHALL have ports ForwardAE, ForwardBE  out  2 each  ALU operand source select.
REQ-015 SHALL have ports StallF, StallD, StallE, StallM  out  1 each  hold the pipeline register of that stage.
REQ-016 SHALL have ports FlushD, FlushE, FlushW  out  1 each  insert a bubble into that stage.
REQ-017 SHALL have port mem_timeout  out  1  sticky memory-abort flag.
REQ-018 SHALL have ports stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-019 SHALL drive ForwardAE = 10 when RegWriteM and RA1E==WA3M; else 01 when RegWriteW and RA1E==WA3W; else 00 (M has priority). ForwardBE SHALL follow the same rule using RA2E.
REQ-020 SHALL never forward for a source register of 4'hF; select 00.
REQ-021 SHALL compute ldrstall = MemtoRegE and (WA3E==RA1D or WA3E==RA2D); ldrstall SHALL drive StallF=StallD=FlushE=1.
REQ-022 SHALL compute PCWrPend = PCSrcD|PCSrcE|PCSrcM; PCWrPend SHALL drive StallF=1 and FlushD=1; PCSrcW SHALL drive FlushD=1.
REQ-023 SHALL drive FlushD=FlushE=1 on BranchTakenE.
REQ-024 SHALL implement FSM states RUN and MEMWAIT.
REQ-025 SHALL move RUN->MEMWAIT when MemReqM=1 and MemAckM=0. It SHALL move MEMWAIT->RUN on MemAckM=1 or when the timeout count reaches MEM_TIMEOUT.
REQ-026 SHALL define memstall = (MemReqM and not MemAckM and not mem_timeout) in either state. memstall SHALL be combinational, so stall starts the same cycle as the request.
REQ-027 SHALL, while memstall, drive StallF/D/E/M=1 and FlushW=1, force FlushD=FlushE=0 (held branch/PC flushes act after release), and keep computing forwarding.
REQ-028 SHALL clear the timeout counter on entry to MEMWAIT and increment it each MEMWAIT cycle. When it reaches MEM_TIMEOUT, it SHALL set mem_timeout, return to RUN, and release all stalls.
REQ-029 SHALL increment stall_cnt each cycle StallF=1 and flush_cnt each cycle FlushE=1. Both SHALL saturate at all-ones, with no wrap.
REQ-030 SHALL give cnt_clr priority over increment; the counter SHALL read 0 the cycle after cnt_clr.
REQ-031 SHALL OR all stall/flush sources when several occur in one cycle, except as overridden by REQ-027.

Reset
REQ-032 SHALL, on reset assertion and without waiting for a clock, set state=RUN, timeout count=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
REQ-033 SHALL, while reset=1, drive StallF/D/E/M=0, FlushD=FlushE=FlushW=1 and ForwardAE=ForwardBE=00.
REQ-034 SHALL abandon any MEMWAIT on reset asserted mid-wait, with no residual stall after deassertion.

Structure
REQ-035 SHALL place the FSM state enum and the forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10 in shared package arm_pipe_pkg.
REQ-036 SHALL instantiate sub-module sat_counter (parameterised width, inc, clr) twice, once for stall_cnt and once for flush_cnt.

Verification
REQ-037 Bench SHALL check: RegWriteM=1, WA3M=3, RA1E=3, RegWriteW=1, WA3W=3 -> ForwardAE=10; same with RA1E=15 -> 00.
REQ-038 Bench SHALL check: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for exactly one cycle; stall_cnt increments by 1.
REQ-039 Bench SHALL check: MemReqM=1, MemAckM low 4 cycles then high -> stalls high 4 cycles, low in the ack cycle, FlushW high 4 cycles, state returns to RUN.
REQ-040 Bench SHALL check: BranchTakenE=1 during memstall -> FlushD=FlushE=0 until ack; then FlushD=FlushE=1.
REQ-041 Bench SHALL check: MEM_TIMEOUT=3, MemAckM never high -> mem_timeout=1 after 3 MEMWAIT cycles, stalls released, flag held until reset.
REQ-042 Bench SHALL check: CNT_W=4, StallF held 20 cycles -> stall_cnt=15; then cnt_clr -> 0; then reset mid-MEMWAIT -> all stalls 0 immediately.
